// File: rtl/aerout_sched_pkg.sv
// Shared types and constants for the AER output scheduler: link FSM states,
// arbitration source encoding and the dropped-spike counter width.
package aerout_sched_pkg;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    WAIT_ACK_HI = 2'd1,
    WAIT_ACK_LO = 2'd2
  } state_e;

  typedef enum logic {
    SRC_SPK = 1'b0,
    SRC_MON = 1'b1
  } src_e;

  localparam int DROP_W = 8;
  localparam logic [DROP_W-1:0] DROP_MAX = '1;

  // Saturating increment for the dropped-spike counter.
  function automatic logic [DROP_W-1:0] sat_inc(input logic [DROP_W-1:0] v);
    return (v == DROP_MAX) ? v : v + DROP_W'(1);
  endfunction

endpackage

// File: rtl/aerout_spk_fifo.sv
// Spike event FIFO: same-cycle write, combinational head, registered full flag.
// A push on a full FIFO is accepted only when a pop frees the slot in that cycle.
module aerout_spk_fifo
  import aerout_sched_pkg::*;
#(
  parameter int M     = 8,
  parameter int DEPTH = 4
) (
  input  logic         CLK,
  input  logic         rst_activity,
  input  logic         push,
  input  logic         pop,
  input  logic [M-1:0] din,
  output logic         full,
  output logic         empty,
  output logic         accept,
  output logic [M-1:0] head
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic          full_q, full_d;
  logic          do_pop;
  logic [M-1:0]  mem [DEPTH];

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = full_q;
  assign head  = mem[rd_ptr_q[AW-1:0]];

  always_comb begin
    do_pop   = pop && !empty;
    accept   = push && (!full_q || do_pop);
    wr_ptr_d = wr_ptr_q + PW'(accept);
    rd_ptr_d = rd_ptr_q + PW'(do_pop);
    // Pointers carry one extra wrap bit, so the difference is the true occupancy.
    full_d   = ((wr_ptr_d - rd_ptr_d) == PW'(DEPTH));
  end

  always_ff @(posedge CLK or posedge rst_activity) begin
    if (rst_activity) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      full_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      full_q   <= full_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (accept) begin
      mem[wr_ptr_q[AW-1:0]] <= din;
    end
  end

endmodule

// File: rtl/aerout_sched.sv
// AER output scheduler: round-robin between the spike FIFO and monitor bursts,
// driving a four-phase REQ/ACK link through a two-flop acknowledge synchronizer.
module aerout_sched
  import aerout_sched_pkg::*;
#(
  parameter int M          = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              CLK,
  input  logic              rst_activity,
  input  logic              SPK_PUSH,
  input  logic [M-1:0]      SPK_ADDR,
  output logic              SPK_FULL,
  input  logic              MON_REQ,
  input  logic [M-1:0]      MON_ADDR,
  input  logic              MON_LAST,
  output logic              MON_GNT,
  output logic [DROP_W-1:0] DROP_CNT,
  output logic              AEROUT_BUSY,
  output logic [M-1:0]      AEROUT_ADDR,
  output logic              AEROUT_REQ,
  input  logic              AEROUT_ACK
);

  state_e              state_q, state_d;
  logic                req_q, req_d;
  logic [M-1:0]        addr_q, addr_d;
  logic                lock_q, lock_d;
  src_e                last_src_q, last_src_d;
  logic [DROP_W-1:0]   drop_q, drop_d;
  logic                ack_meta_q, ack_meta_d;
  logic                ack_s_q, ack_s_d;
  logic [1:0]          sync_vld_q, sync_vld_d;

  logic                fifo_full;
  logic                fifo_empty;
  logic                fifo_accept;
  logic [M-1:0]        fifo_head;
  logic                spk_elig;
  logic                mon_elig;
  logic                can_grant;
  logic                grant_spk;
  logic                grant_mon;

  aerout_spk_fifo #(
    .M     (M),
    .DEPTH (FIFO_DEPTH)
  ) u_spk_fifo (
    .CLK          (CLK),
    .rst_activity (rst_activity),
    .push         (SPK_PUSH),
    .pop          (grant_spk),
    .din          (SPK_ADDR),
    .full         (fifo_full),
    .empty        (fifo_empty),
    .accept       (fifo_accept),
    .head         (fifo_head)
  );

  // sync_vld marks when ack_s holds a real sample of the pin rather than its
  // reset value, so no grant can slip out right after reset with ACK still high.
  always_comb begin
    ack_meta_d = AEROUT_ACK;
    ack_s_d    = ack_meta_q;
    sync_vld_d = {sync_vld_q[0], 1'b1};
  end

  always_comb begin
    spk_elig  = !fifo_empty && !lock_q;
    mon_elig  = MON_REQ;
    can_grant = (state_q == IDLE) && !ack_s_q && sync_vld_q[1];
    grant_spk = can_grant && spk_elig && (!mon_elig || (last_src_q == SRC_MON));
    grant_mon = can_grant && mon_elig && !grant_spk;
  end

  always_comb begin
    state_d    = state_q;
    req_d      = req_q;
    addr_d     = addr_q;
    lock_d     = lock_q;
    last_src_d = last_src_q;
    drop_d     = (SPK_PUSH && !fifo_accept) ? sat_inc(drop_q) : drop_q;
    case (state_q)
      IDLE: begin
        if (grant_spk || grant_mon) begin
          state_d    = WAIT_ACK_HI;
          req_d      = 1'b1;
          addr_d     = grant_spk ? fifo_head : MON_ADDR;
          last_src_d = grant_spk ? SRC_SPK : SRC_MON;
          if (grant_mon) begin
            lock_d = !MON_LAST;
          end
        end
      end
      WAIT_ACK_HI: begin
        if (ack_s_q) begin
          req_d   = 1'b0;
          state_d = WAIT_ACK_LO;
        end
      end
      WAIT_ACK_LO: begin
        if (!ack_s_q) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        req_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge rst_activity) begin
    if (rst_activity) begin
      state_q    <= IDLE;
      req_q      <= 1'b0;
      addr_q     <= '0;
      lock_q     <= 1'b0;
      last_src_q <= SRC_MON;
      drop_q     <= '0;
      ack_meta_q <= 1'b0;
      ack_s_q    <= 1'b0;
      sync_vld_q <= '0;
    end else begin
      state_q    <= state_d;
      req_q      <= req_d;
      addr_q     <= addr_d;
      lock_q     <= lock_d;
      last_src_q <= last_src_d;
      drop_q     <= drop_d;
      ack_meta_q <= ack_meta_d;
      ack_s_q    <= ack_s_d;
      sync_vld_q <= sync_vld_d;
    end
  end

  assign SPK_FULL    = fifo_full;
  assign MON_GNT     = grant_mon;
  assign DROP_CNT    = drop_q;
  assign AEROUT_BUSY = (state_q != IDLE) || lock_q;
  assign AEROUT_ADDR = addr_q;
  assign AEROUT_REQ  = req_q;

endmodule
